// File: rtl/micro_seq_pkg.sv
// Shared definitions for the micro-sequencer: opcodes, FSM states, operand selects,
// timeout limit and the registered Moore strobe bundle.
package micro_seq_pkg;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        OPERAND = 3'd2,
        MEMACC  = 3'd3,
        ALU_SET = 3'd4,
        ALU_WB  = 3'd5,
        HALT    = 3'd6
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_LDD = 4'h2;
    localparam logic [3:0] OP_STD = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_LGL = 4'h6;
    localparam logic [3:0] OP_LGH = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] SEL_AR = 2'b00;
    localparam logic [1:0] SEL_DR = 2'b01;
    localparam logic [1:0] SEL_GR = 2'b10;
    localparam logic [1:0] SEL_PR = 2'b11;

    // Number of request cycles allowed before a transfer is declared dead.
    localparam int TIMEOUT_LIMIT = 16;

    typedef struct packed {
        logic       pr_on_add;
        logic       ar_on_add;
        logic       mem_rd;
        logic       mem_wr;
        logic       dr_on_data;
        logic       alu_2_data;
        logic       dr_load;
        logic       alu_sel;
        logic       alu_cin;
        logic [1:0] sel_a;
        logic [1:0] sel_b;
        logic       halted;
    } strobes_t;

    function automatic logic is_illegal(input logic [3:0] op);
        return (op > OP_JMP) && (op != OP_HLT);
    endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Control bus between the micro-sequencer and the 8-bit datapath/memory.
// master = sequencer side, slave = datapath/memory side.
interface micro_sequencer_if;

    logic [7:0] machine_code;
    logic       mem_ready;
    logic       pr_on_add;
    logic       increment_pr;
    logic       ar_on_pr;
    logic       data_on_ir;
    logic       data_on_ar;
    logic       ar_on_add;
    logic       data_on_dr;
    logic       dr_on_data;
    logic       lsb_on_gr;
    logic       msb_on_gr;
    logic       ALU_cin;
    logic       ALU_sel;
    logic       alu_2_data;
    logic [1:0] add_sel_a;
    logic [1:0] add_sel_b;
    logic       mem_rd;
    logic       mem_wr;
    logic       halted;
    logic       illegal_op;
    logic       bus_err;

    modport master (
        input  machine_code, mem_ready,
        output pr_on_add, increment_pr, ar_on_pr, data_on_ir, data_on_ar,
               ar_on_add, data_on_dr, dr_on_data, lsb_on_gr, msb_on_gr,
               ALU_cin, ALU_sel, alu_2_data, add_sel_a, add_sel_b,
               mem_rd, mem_wr, halted, illegal_op, bus_err
    );

    modport slave (
        output machine_code, mem_ready,
        input  pr_on_add, increment_pr, ar_on_pr, data_on_ir, data_on_ar,
               ar_on_add, data_on_dr, dr_on_data, lsb_on_gr, msb_on_gr,
               ALU_cin, ALU_sel, alu_2_data, add_sel_a, add_sel_b,
               mem_rd, mem_wr, halted, illegal_op, bus_err
    );

endinterface

// File: rtl/micro_seq_timer.sv
// Memory-request watchdog: counts consecutive request cycles and flags the cycle
// in which the last allowed request cycle passes without mem_ready.
module micro_seq_timer
    import micro_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ready,
    output logic expired
);

    logic [3:0] cnt;

    assign expired = req & ~ready & (cnt == 4'(TIMEOUT_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst || !req || ready || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Instruction sequencer for the 8-bit accumulator datapath. Optional memory
// watchdog is enabled with `define MICRO_SEQ_MEM_TIMEOUT_EN.
module micro_sequencer
    import micro_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    micro_sequencer_if.master bus
);

    state_t     state;
    state_t     nxt;
    strobes_t   stb;
    logic [3:0] op;
    logic [3:0] cur_op;
    logic       req;
    logic       done;
    logic       xfer;
    logic       expired;
    logic       unused_operand_bits;

    function automatic state_t next_state(input state_t s, input logic [3:0] o,
                                          input logic fin, input logic tmo);
        state_t n;
        n = s;
        if (tmo) begin
            n = HALT;
        end else begin
            case (s)
                FETCH:   if (fin) n = DECODE;
                DECODE: begin
                    case (o)
                        OP_LDA, OP_LGL, OP_LGH, OP_JMP: n = OPERAND;
                        OP_LDD, OP_STD:                 n = MEMACC;
                        OP_ADD, OP_SUB:                 n = ALU_SET;
                        OP_HLT:                         n = HALT;
                        default:                        n = FETCH;
                    endcase
                end
                OPERAND: if (fin) n = FETCH;
                MEMACC:  if (fin) n = FETCH;
                ALU_SET: n = ALU_WB;
                ALU_WB:  n = FETCH;
                default: n = HALT;
            endcase
        end
        return n;
    endfunction

    // Level strobes that depend only on the state being entered.
    function automatic strobes_t moore_strobes(input state_t s, input logic [3:0] o);
        strobes_t t;
        t = '0;
        case (s)
            FETCH, OPERAND: begin
                t.pr_on_add = 1'b1;
                t.mem_rd    = 1'b1;
            end
            MEMACC: begin
                t.ar_on_add = 1'b1;
                if (o == OP_STD) begin
                    t.mem_wr     = 1'b1;
                    t.dr_on_data = 1'b1;
                end else begin
                    t.mem_rd = 1'b1;
                end
            end
            ALU_SET, ALU_WB: begin
                t.sel_a      = SEL_DR;
                t.sel_b      = SEL_GR;
                t.alu_sel    = (o == OP_SUB);
                t.alu_cin    = (o == OP_SUB);
                t.alu_2_data = (s == ALU_WB);
                t.dr_load    = (s == ALU_WB);
            end
            HALT:    t.halted = 1'b1;
            default: t = '0;
        endcase
        return t;
    endfunction

    // The IR is only trusted in DECODE; later states use the latched opcode.
    assign cur_op = (state == DECODE) ? bus.machine_code[7:4] : op;
    assign unused_operand_bits = ^bus.machine_code[3:0];

    // A transfer exists only while a request is out, so stray mem_ready is ignored.
    assign req  = stb.mem_rd | stb.mem_wr;
    assign done = req & bus.mem_ready;
    assign xfer = done & ~rst;
    assign nxt  = next_state(state, cur_op, done, expired);

    // Outputs come out of reset at zero; the first fetch request follows one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            stb   <= '0;
        end else begin
            state <= nxt;
            stb   <= moore_strobes(nxt, cur_op);
        end
    end

    always_ff @(posedge clk) begin
        if (state == DECODE) begin
            op <= bus.machine_code[7:4];
        end
    end

    assign bus.pr_on_add  = stb.pr_on_add;
    assign bus.ar_on_add  = stb.ar_on_add;
    assign bus.mem_rd     = stb.mem_rd;
    assign bus.mem_wr     = stb.mem_wr;
    assign bus.dr_on_data = stb.dr_on_data;
    assign bus.alu_2_data = stb.alu_2_data;
    assign bus.ALU_sel    = stb.alu_sel;
    assign bus.ALU_cin    = stb.alu_cin;
    assign bus.add_sel_a  = stb.sel_a;
    assign bus.add_sel_b  = stb.sel_b;
    assign bus.halted     = stb.halted;

    // Load and increment pulses fire only in the cycle the memory completes.
    assign bus.data_on_ir   = xfer & (state == FETCH);
    assign bus.increment_pr = xfer & ((state == FETCH) || ((state == OPERAND) && (op != OP_JMP)));
    assign bus.data_on_ar   = xfer & (state == OPERAND) & (op == OP_LDA);
    assign bus.lsb_on_gr    = xfer & (state == OPERAND) & (op == OP_LGL);
    assign bus.msb_on_gr    = xfer & (state == OPERAND) & (op == OP_LGH);
    assign bus.ar_on_pr     = xfer & (state == OPERAND) & (op == OP_JMP);
    assign bus.data_on_dr   = (xfer & (state == MEMACC) & (op == OP_LDD)) | stb.dr_load;
    assign bus.illegal_op   = (state == DECODE) & is_illegal(bus.machine_code[7:4]);

`ifdef MICRO_SEQ_MEM_TIMEOUT_EN
    logic bus_err_q;

    micro_seq_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ready   (bus.mem_ready),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err_q <= 1'b0;
        end else if (expired) begin
            bus_err_q <= 1'b1;
        end
    end

    assign bus.bus_err = bus_err_q;
`else
    assign expired     = 1'b0;
    assign bus.bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: a per-instruction timeline model supplies the
// expected outputs of every cycle, plus literal pulse counts and latency gaps.
module tb_micro_sequencer;

    typedef struct packed {
        logic       pr_on_add;
        logic       increment_pr;
        logic       ar_on_pr;
        logic       data_on_ir;
        logic       data_on_ar;
        logic       ar_on_add;
        logic       data_on_dr;
        logic       dr_on_data;
        logic       lsb_on_gr;
        logic       msb_on_gr;
        logic       alu_cin;
        logic       alu_sel;
        logic       alu_2_data;
        logic [1:0] sel_a;
        logic [1:0] sel_b;
        logic       mem_rd;
        logic       mem_wr;
        logic       halted;
        logic       illegal_op;
        logic       bus_err;
    } outs_t;

    typedef struct packed {
        logic       chk;
        logic       rst;
        logic       rdy;
        logic [7:0] code;
        outs_t      o;
    } cyc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    micro_sequencer_if bus ();

    micro_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cyc_t       plan[$];
    string      tags[$];
    int         fidx[$];
    logic [7:0] ir = 8'h00;
    int         checks = 0;
    int         failures = 0;
    int         n_ir = 0, n_inc = 0, n_ar = 0, n_jmp = 0, n_alu = 0, n_ill = 0;

    function automatic outs_t sample();
        outs_t s;
        s.pr_on_add    = bus.pr_on_add;
        s.increment_pr = bus.increment_pr;
        s.ar_on_pr     = bus.ar_on_pr;
        s.data_on_ir   = bus.data_on_ir;
        s.data_on_ar   = bus.data_on_ar;
        s.ar_on_add    = bus.ar_on_add;
        s.data_on_dr   = bus.data_on_dr;
        s.dr_on_data   = bus.dr_on_data;
        s.lsb_on_gr    = bus.lsb_on_gr;
        s.msb_on_gr    = bus.msb_on_gr;
        s.alu_cin      = bus.ALU_cin;
        s.alu_sel      = bus.ALU_sel;
        s.alu_2_data   = bus.alu_2_data;
        s.sel_a        = bus.add_sel_a;
        s.sel_b        = bus.add_sel_b;
        s.mem_rd       = bus.mem_rd;
        s.mem_wr       = bus.mem_wr;
        s.halted       = bus.halted;
        s.illegal_op   = bus.illegal_op;
        s.bus_err      = bus.bus_err;
        return s;
    endfunction

    task automatic push(input string t, input logic r, input logic rdy, input outs_t o, input logic chk);
        cyc_t c;
        c.chk  = chk;
        c.rst  = r;
        c.rdy  = rdy;
        c.code = ir;
        c.o    = o;
        plan.push_back(c);
        tags.push_back(t);
    endtask

    // A memory transfer: w cycles of requests, the last one completing with its load pulses.
    task automatic xfer(input string t, input int w, input outs_t hold, input outs_t load);
        outs_t o;
        for (int i = 1; i <= w; i++) begin
            o = (i == w) ? outs_t'(hold | load) : hold;
            push(t, 1'b0, (i == w), o, 1'b1);
        end
    endtask

    task automatic reset_seq(input string t, input int n);
        outs_t z;
        z = '0;
        for (int i = 0; i < n; i++) push(t, 1'b1, 1'b0, z, 1'b0);
        // First cycle out of reset: all outputs low and a stray mem_ready is ignored.
        push({t, "_idle"}, 1'b0, 1'b1, z, 1'b1);
    endtask

    // Whole-instruction timeline: fetch, decode, then the class-specific tail.
    task automatic instr(input string t, input logic [7:0] code, input int w1, input int w2);
        outs_t      h, l, d, a, z;
        logic [3:0] opc;
        z = '0;
        h = z; h.pr_on_add = 1'b1; h.mem_rd = 1'b1;
        l = z; l.data_on_ir = 1'b1; l.increment_pr = 1'b1;
        xfer({t, "_fetch"}, w1, h, l);
        ir  = code;
        opc = code[7:4];
        d = z; d.illegal_op = (opc >= 4'h9) && (opc <= 4'hE);
        push({t, "_decode"}, 1'b0, 1'b1, d, 1'b1);
        l = z;
        case (opc)
            4'h1: begin l.increment_pr = 1'b1; l.data_on_ar = 1'b1; xfer({t, "_opnd"}, w2, h, l); end
            4'h6: begin l.increment_pr = 1'b1; l.lsb_on_gr  = 1'b1; xfer({t, "_opnd"}, w2, h, l); end
            4'h7: begin l.increment_pr = 1'b1; l.msb_on_gr  = 1'b1; xfer({t, "_opnd"}, w2, h, l); end
            4'h8: begin l.ar_on_pr = 1'b1; xfer({t, "_opnd"}, w2, h, l); end
            4'h2: begin
                h = z; h.ar_on_add = 1'b1; h.mem_rd = 1'b1; l.data_on_dr = 1'b1;
                xfer({t, "_mem"}, w2, h, l);
            end
            4'h3: begin
                h = z; h.ar_on_add = 1'b1; h.mem_wr = 1'b1; h.dr_on_data = 1'b1;
                xfer({t, "_mem"}, w2, h, z);
            end
            4'h4, 4'h5: begin
                a = z; a.sel_a = 2'b01; a.sel_b = 2'b10;
                a.alu_sel = (opc == 4'h5); a.alu_cin = (opc == 4'h5);
                push({t, "_aluset"}, 1'b0, 1'b1, a, 1'b1);
                a.alu_2_data = 1'b1; a.data_on_dr = 1'b1;
                push({t, "_aluwb"}, 1'b0, 1'b1, a, 1'b1);
            end
            default: ;
        endcase
    endtask

    task automatic halt_cycles(input string t, input int n, input logic err);
        outs_t o;
        o = '0; o.halted = 1'b1; o.bus_err = err;
        for (int i = 0; i < n; i++) push(t, 1'b0, i[0], o, 1'b1);
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    initial begin
        outs_t h, act;
        bus.mem_ready    = 1'b0;
        bus.machine_code = 8'h00;

        reset_seq("rst0", 2);
        instr("nop",  8'h00, 1, 0);
        instr("lda",  8'h10, 1, 3);
        instr("sub",  8'h50, 1, 0);
        instr("add",  8'h40, 2, 0);
        instr("lgl",  8'h60, 1, 1);
        instr("lgh",  8'h70, 1, 2);
        instr("jmp",  8'h80, 2, 1);
        instr("ill",  8'hC3, 1, 0);
        instr("ldd",  8'h20, 1, 2);
        instr("std",  8'h30, 1, 3);
        instr("hlt",  8'hF0, 1, 0);
        halt_cycles("halt", 20, 1'b0);

        // Reset asserted in the 5th request cycle of a fetch, with mem_ready high.
        reset_seq("rst1", 2);
        h = '0; h.pr_on_add = 1'b1; h.mem_rd = 1'b1;
        for (int i = 0; i < 4; i++) push("abort_wait", 1'b0, 1'b0, h, 1'b1);
        push("abort_rst", 1'b1, 1'b1, h, 1'b1);
        push("abort_after", 1'b0, 1'b0, outs_t'('0), 1'b1);
        instr("nop2", 8'h00, 1, 0);
        push("refetch", 1'b0, 1'b0, h, 1'b1);

`ifdef MICRO_SEQ_MEM_TIMEOUT_EN
        reset_seq("rst2", 2);
        for (int i = 0; i < 16; i++) push("tmo_wait", 1'b0, 1'b0, h, 1'b1);
        halt_cycles("tmo_halt", 5, 1'b1);
        reset_seq("rst3", 2);
`endif

        foreach (plan[i]) begin
            @(negedge clk);
            rst              = plan[i].rst;
            bus.mem_ready    = plan[i].rdy;
            bus.machine_code = plan[i].code;
            #1;
            act = sample();
            if (plan[i].chk) begin
                checks++;
                if (act !== plan[i].o) begin
                    failures++;
                    $display("FAIL %s cycle=%0d outputs actual=%b required=%b",
                             tags[i], i, act, plan[i].o);
                end
            end
            if (act.data_on_ir) begin n_ir++; fidx.push_back(i); end
            if (act.increment_pr) n_inc++;
            if (act.data_on_ar) n_ar++;
            if (act.ar_on_pr) n_jmp++;
            if (act.alu_2_data) n_alu++;
            if (act.illegal_op) n_ill++;
        end

        check_int("data_on_ir_count", n_ir, 12);
        check_int("increment_pr_count", n_inc, 15);
        check_int("data_on_ar_count", n_ar, 1);
        check_int("ar_on_pr_count", n_jmp, 1);
        check_int("alu_2_data_count", n_alu, 2);
        check_int("illegal_op_count", n_ill, 1);
        // NOP: fetch done, decode, next fetch done one cycle later (3 cycles including it).
        check_int("nop_to_lda_gap", (fidx.size() >= 4) ? (fidx[1] - fidx[0]) : -1, 2);
        // SUB: decode, ALU_SET, ALU_WB, then a 2-cycle ADD fetch.
        check_int("sub_to_add_gap", (fidx.size() >= 4) ? (fidx[3] - fidx[2]) : -1, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
